fifo_mem_writer: RTL and testbench

Drains 16-bit samples from the read side of the `dcfifo` and writes them into consecutive `mem16kb` locations starting at a programmed base address. It can optionally read back each word and compare it against the value written. It is the consumer counterpart of the memory-to-FIFO load path and sits in the `rd_clk` domain of the FIFO, ahead of the FIR coefficient/sample store.

---
 rtl/fir_mem_pkg.sv | 18 +
 rtl/fmw_addr_gen.sv | 40 ++++
 rtl/fifo_mem_writer.sv | 156 +++++++++++++++
 tb/tb_fifo_mem_writer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mem_pkg.sv
// rtl/fir_mem_pkg.sv - shared widths and state encoding for the FIR memory path
package fir_mem_pkg;

    localparam int DWIDTH    = 16;
    localparam int MAWIDTH   = 12;
    localparam int LWIDTH    = 13;
    localparam int MEM_WORDS = 4096;

    typedef enum logic [2:0] {
        FMW_IDLE,
        FMW_POP,
        FMW_WR,
        FMW_RD,
        FMW_CMP,
        FMW_DONE
    } fmw_state_t;

endpackage

// File: rtl/fmw_addr_gen.sv
// rtl/fmw_addr_gen.sv - latched base plus word counter, wrapping address and last-word detect
module fmw_addr_gen
    import fir_mem_pkg::*;
#(
    parameter int MAWIDTH = fir_mem_pkg::MAWIDTH,
    parameter int LWIDTH  = fir_mem_pkg::LWIDTH
) (
    input  logic               i_clk,
    input  logic               i_areset_n,
    input  logic               i_load,
    input  logic [MAWIDTH-1:0] i_base,
    input  logic [LWIDTH-1:0]  i_length,
    input  logic               i_advance,
    output logic [MAWIDTH-1:0] o_addr,
    output logic               o_last
);

    logic [MAWIDTH-1:0] r_base;
    logic [LWIDTH-1:0]  r_len;
    logic [LWIDTH-1:0]  r_count;

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_base  <= '0;
            r_len   <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_base  <= i_base;
            r_len   <= i_length;
            r_count <= '0;
        end else if (i_advance) begin
            r_count <= r_count + LWIDTH'(1);
        end
    end

    // Truncating the sum gives the modulo-2^MAWIDTH wrap for free.
    assign o_addr = r_base + r_count[MAWIDTH-1:0];
    assign o_last = (r_count == (r_len - LWIDTH'(1)));

endmodule

// File: rtl/fifo_mem_writer.sv
// rtl/fifo_mem_writer.sv - drains dcfifo samples into consecutive mem16kb words
// with optional read-back compare; lives in the FIFO rd_clk domain.
module fifo_mem_writer
    import fir_mem_pkg::*;
#(
    parameter int DWIDTH  = fir_mem_pkg::DWIDTH,
    parameter int MAWIDTH = fir_mem_pkg::MAWIDTH,
    parameter int LWIDTH  = fir_mem_pkg::LWIDTH
) (
    input  logic               i_clk,
    input  logic               i_areset_n,
    input  logic               i_start,
    input  logic [MAWIDTH-1:0] i_base_addr,
    input  logic [LWIDTH-1:0]  i_length,
    input  logic               i_verify,
    output logic               o_fifo_read,
    input  logic [DWIDTH-1:0]  i_fifo_q,
    input  logic               i_fifo_empty,
    output logic [MAWIDTH-1:0] o_mem_addr,
    output logic [DWIDTH-1:0]  o_mem_data_in,
    output logic               o_mem_wen_n,
    input  logic [DWIDTH-1:0]  i_mem_data_out,
    output logic               o_busy,
    output logic               o_done,
    output logic [LWIDTH-1:0]  o_words_written,
    output logic               o_mismatch,
    output logic [MAWIDTH-1:0] o_err_addr
);

    fmw_state_t r_state;
    fmw_state_t w_state_next;

    logic               r_verify;
    logic               r_fifo_read;
    logic               r_mem_wen_n;
    logic [MAWIDTH-1:0] r_mem_addr;
    logic [DWIDTH-1:0]  r_hold;
    logic               r_busy;
    logic               r_done;
    logic [LWIDTH-1:0]  r_words;
    logic               r_mismatch;
    logic [MAWIDTH-1:0] r_err_addr;

    logic               w_accept;
    logic               w_advance;
    logic               w_last;
    logic [MAWIDTH-1:0] w_addr;

    assign w_accept  = (r_state == FMW_IDLE) && i_start && (i_length != '0);
    assign w_advance = ((r_state == FMW_WR) && !r_verify) || (r_state == FMW_CMP);

    fmw_addr_gen #(
        .MAWIDTH (MAWIDTH),
        .LWIDTH  (LWIDTH)
    ) u_addr_gen (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_load     (w_accept),
        .i_base     (i_base_addr),
        .i_length   (i_length),
        .i_advance  (w_advance),
        .o_addr     (w_addr),
        .o_last     (w_last)
    );

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state <= FMW_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // POP leaves only after the registered pop strobe has actually been high.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            FMW_IDLE: begin
                if (i_start) begin
                    w_state_next = (i_length == '0) ? FMW_DONE : FMW_POP;
                end
            end
            FMW_POP: begin
                if (r_fifo_read) begin
                    w_state_next = FMW_WR;
                end
            end
            FMW_WR: begin
                if (r_verify) begin
                    w_state_next = FMW_RD;
                end else begin
                    w_state_next = w_last ? FMW_DONE : FMW_POP;
                end
            end
            FMW_RD:   w_state_next = FMW_CMP;
            FMW_CMP:  w_state_next = w_last ? FMW_DONE : FMW_POP;
            FMW_DONE: w_state_next = FMW_IDLE;
            default:  w_state_next = FMW_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    // The empty flag can only fall behind our back, never rise, since we are the sole reader.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_verify    <= 1'b0;
            r_fifo_read <= 1'b0;
            r_mem_wen_n <= 1'b1;
            r_mem_addr  <= '0;
            r_hold      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_words     <= '0;
            r_mismatch  <= 1'b0;
            r_err_addr  <= '0;
        end else begin
            r_fifo_read <= (w_state_next == FMW_POP) && !i_fifo_empty;
            r_mem_wen_n <= (w_state_next != FMW_WR);
            r_busy      <= (w_state_next != FMW_IDLE);
            r_done      <= (w_state_next == FMW_DONE);
            if ((w_state_next == FMW_WR) || (w_state_next == FMW_RD)) begin
                r_mem_addr <= w_addr;
            end
            if (r_state == FMW_WR) begin
                r_hold <= i_fifo_q;
            end
            if (w_accept) begin
                r_verify   <= i_verify;
                r_words    <= '0;
                r_mismatch <= 1'b0;
                r_err_addr <= '0;
            end else begin
                if (w_state_next == FMW_WR) begin
                    r_words <= r_words + LWIDTH'(1);
                end
                if ((r_state == FMW_CMP) && (i_mem_data_out != r_hold) && !r_mismatch) begin
                    r_mismatch <= 1'b1;
                    r_err_addr <= r_mem_addr;
                end
            end
        end
    end

    // fifo_q is itself a FIFO register output, so it is forwarded during WR
    // and the captured copy is presented the rest of the time.
    assign o_mem_data_in   = (r_state == FMW_WR) ? i_fifo_q : r_hold;
    assign o_fifo_read     = r_fifo_read;
    assign o_mem_addr      = r_mem_addr;
    assign o_mem_wen_n     = r_mem_wen_n;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_words_written = r_words;
    assign o_mismatch      = r_mismatch;
    assign o_err_addr      = r_err_addr;

endmodule

// File: tb/tb_fifo_mem_writer.sv
// tb/tb_fifo_mem_writer.sv - directed scoreboard bench with FIFO and memory models
module tb_fifo_mem_writer;
    import fir_mem_pkg::*;

    typedef struct {
        logic [MAWIDTH-1:0] a;
        logic [DWIDTH-1:0]  d;
    } wr_t;

    logic               clk = 1'b0;
    logic               areset_n = 1'b1;
    logic               start = 1'b0;
    logic [MAWIDTH-1:0] base_addr = '0;
    logic [LWIDTH-1:0]  length = '0;
    logic               verify = 1'b0;
    logic               fifo_read;
    logic [DWIDTH-1:0]  fifo_q = '0;
    logic               fifo_empty = 1'b1;
    logic [MAWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0]  mem_data_in;
    logic               mem_wen_n;
    logic [DWIDTH-1:0]  mem_data_out = '0;
    logic               busy;
    logic               done;
    logic [LWIDTH-1:0]  words_written;
    logic               mismatch;
    logic [MAWIDTH-1:0] err_addr;

    logic [DWIDTH-1:0]  mem [0:MEM_WORDS-1];
    logic [DWIDTH-1:0]  fq [$];
    wr_t                exp_wr [$];
    logic               fault_en = 1'b0;
    logic [MAWIDTH-1:0] fault_addr = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int rd_empty_viol = 0;
    int wr_seen = 0;
    int rd_seen = 0;

    always #5 clk = ~clk;

    fifo_mem_writer dut (
        .i_clk           (clk),
        .i_areset_n      (areset_n),
        .i_start         (start),
        .i_base_addr     (base_addr),
        .i_length        (length),
        .i_verify        (verify),
        .o_fifo_read     (fifo_read),
        .i_fifo_q        (fifo_q),
        .i_fifo_empty    (fifo_empty),
        .o_mem_addr      (mem_addr),
        .o_mem_data_in   (mem_data_in),
        .o_mem_wen_n     (mem_wen_n),
        .i_mem_data_out  (mem_data_out),
        .o_busy          (busy),
        .o_done          (done),
        .o_words_written (words_written),
        .o_mismatch      (mismatch),
        .o_err_addr      (err_addr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Non-showahead FIFO: q updates after the pop edge, empty follows one edge later.
    always @(posedge clk) begin
        if (fifo_read && fq.size() != 0) fifo_q <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
    end

    // Synchronous memory with an optional read-data fault at one address.
    always @(posedge clk) begin
        if (!mem_wen_n) mem[mem_addr] <= mem_data_in;
        mem_data_out <= (fault_en && mem_addr == fault_addr) ? ~mem[mem_addr] : mem[mem_addr];
    end

    always @(negedge clk) begin
        if (fifo_read) rd_seen++;
        if (fifo_read && fifo_empty) rd_empty_viol++;
        if (!mem_wen_n) begin
            wr_t e;
            wr_seen++;
            check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.a));
                check("wr_data", 32'(mem_data_in), 32'(e.d));
            end
        end
    end

    task automatic push_word(input logic [MAWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
        fq.push_back(d);
        exp_wr.push_back('{a: a, d: d});
    endtask

    task automatic run_xfer(input logic [MAWIDTH-1:0] b, input logic [LWIDTH-1:0] l,
                            input logic v, output int cycles, output int busy_low);
        repeat (2) @(negedge clk);
        base_addr = b;
        length    = l;
        verify    = v;
        start     = 1'b1;
        busy_low  = 0;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < 400) begin
            if (!busy) busy_low++;
            @(negedge clk);
            cycles++;
        end
        if (!done) cycles = -1;
        else if (!busy) busy_low++;
    endtask

    initial begin
        int cyc;
        int blow;
        int wr0;
        int rd0;

        #2 areset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_fifo_read", 32'(fifo_read), 32'd0);
        check("rst_wen_n", 32'(mem_wen_n), 32'd1);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data_in", 32'(mem_data_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_words", 32'(words_written), 32'd0);
        check("rst_mismatch", 32'(mismatch), 32'd0);
        check("rst_err_addr", 32'(err_addr), 32'd0);
        areset_n = 1'b1;

        // Plain transfer
        push_word(12'd1, 16'd14514);
        push_word(12'd2, 16'd9810);
        push_word(12'd3, 16'd8750);
        run_xfer(12'd1, 13'd3, 1'b0, cyc, blow);
        check("plain_done_latency", 32'(cyc), 32'd7);
        check("plain_busy_held", 32'(blow), 32'd0);
        check("plain_words", 32'(words_written), 32'd3);
        @(negedge clk);
        check("plain_mem1", 32'(mem[1]), 32'd14514);
        check("plain_mem2", 32'(mem[2]), 32'd9810);
        check("plain_mem3", 32'(mem[3]), 32'd8750);

        // Empty stall
        exp_wr.push_back('{a: 12'd10, d: 16'd2000});
        exp_wr.push_back('{a: 12'd11, d: 16'd4000});
        fork
            run_xfer(12'd10, 13'd2, 1'b0, cyc, blow);
            begin
                repeat (10) @(negedge clk);
                fq.push_back(16'd2000);
                repeat (10) @(negedge clk);
                fq.push_back(16'd4000);
            end
        join
        check("stall_completed", 32'(cyc > 20), 32'd1);
        check("stall_busy_held", 32'(blow), 32'd0);
        check("stall_rd_when_empty", 32'(rd_empty_viol), 32'd0);
        check("stall_words", 32'(words_written), 32'd2);

        // Address wrap
        push_word(12'd4095, 16'd30610);
        push_word(12'd0, 16'd32610);
        run_xfer(12'd4095, 13'd2, 1'b0, cyc, blow);
        check("wrap_done_latency", 32'(cyc), 32'd5);
        @(negedge clk);
        check("wrap_mem4095", 32'(mem[4095]), 32'd30610);
        check("wrap_mem0", 32'(mem[0]), 32'd32610);

        // Verify with a read-back fault on the second word
        fault_addr = 12'd501;
        fault_en   = 1'b1;
        push_word(12'd500, 16'd111);
        push_word(12'd501, 16'd222);
        push_word(12'd502, 16'd333);
        run_xfer(12'd500, 13'd3, 1'b1, cyc, blow);
        fault_en = 1'b0;
        check("verify_done_latency", 32'(cyc), 32'd13);
        check("verify_mismatch", 32'(mismatch), 32'd1);
        check("verify_err_addr", 32'(err_addr), 32'd501);
        check("verify_words", 32'(words_written), 32'd3);

        // Clean verify run clears the sticky flag
        push_word(12'd700, 16'd4321);
        push_word(12'd701, 16'd1234);
        run_xfer(12'd700, 13'd2, 1'b1, cyc, blow);
        check("clean_done_latency", 32'(cyc), 32'd9);
        check("clean_mismatch", 32'(mismatch), 32'd0);
        check("clean_err_addr", 32'(err_addr), 32'd0);

        // Length zero
        wr0 = wr_seen;
        rd0 = rd_seen;
        run_xfer(12'd300, 13'd0, 1'b0, cyc, blow);
        check("len0_done_latency", 32'(cyc), 32'd1);
        check("len0_no_writes", 32'(wr_seen - wr0), 32'd0);
        check("len0_no_reads", 32'(rd_seen - rd0), 32'd0);

        // Second start during a 4-word transfer is ignored
        push_word(12'd20, 16'd100);
        push_word(12'd21, 16'd101);
        push_word(12'd22, 16'd102);
        push_word(12'd23, 16'd103);
        fork
            run_xfer(12'd20, 13'd4, 1'b0, cyc, blow);
            begin
                repeat (5) @(negedge clk);
                start     = 1'b1;
                base_addr = 12'd900;
                length    = 13'd2;
                verify    = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check("busy_start_latency", 32'(cyc), 32'd9);
        check("busy_start_words", 32'(words_written), 32'd4);
        repeat (4) @(negedge clk);
        check("busy_start_idle", 32'(busy), 32'd0);

        // Reset while WR is presented
        push_word(12'd40, 16'd7001);
        fq.push_back(16'd7002);
        repeat (2) @(negedge clk);
        base_addr = 12'd40;
        length    = 13'd2;
        verify    = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (mem_wen_n && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("rstmid_reached_wr", 32'(mem_wen_n), 32'd0);
        #1 areset_n = 1'b0;
        #1;
        check("rstmid_wen_n", 32'(mem_wen_n), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_fifo_read", 32'(fifo_read), 32'd0);
        check("rstmid_words", 32'(words_written), 32'd0);
        fq.delete();
        repeat (2) @(negedge clk);
        areset_n = 1'b1;
        push_word(12'd60, 16'd5555);
        run_xfer(12'd60, 13'd1, 1'b0, cyc, blow);
        check("post_rst_latency", 32'(cyc), 32'd3);
        check("post_rst_words", 32'(words_written), 32'd1);
        @(negedge clk);
        check("post_rst_mem60", 32'(mem[60]), 32'd5555);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_wr.size()), 32'd0);
        check("never_read_empty", 32'(rd_empty_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
